muldiv_sequencer: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS datapath. The decode stage hands it MULT/MULTU/DIV/DIVU operands with a one-cycle start pulse. It then runs a fixed-length shift-add or restoring-divide sequence and writes HI/LO when finished. It drives the processor stall line when an MFHI/MFLO arrives before the result is ready.

---
 rtl/muldiv_pkg.sv | 11 +
 rtl/muldiv_step.sv | 27 ++
 rtl/muldiv_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and counter sizing for muldiv_sequencer
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration; acc/opnd/div in, acc_nxt out; divide path present only with MULDIV_DIV_EN
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] diff;
  assign diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  always_comb begin
    acc_nxt = !div ? {sum, acc[WIDTH-1:1]} :
              diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
              {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
`else
  logic unused_div;
  assign unused_div = div;
  always_comb begin
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end
`endif
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; ports clk, reset, start, op, a, b, rd_hilo -> busy, stall, done, div_zero, hi, lo; divide enabled by MULDIV_DIV_EN
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_nxt, div_entry;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0] opnd, am, bm, fix_hi, fix_lo;
  logic sgn, is_div, div_r, neg_q, fix_dz, last;
  assign sgn    = op == OP_MULT || op == OP_DIV;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign am     = (sgn && a[WIDTH-1]) ? -a : a;
  assign bm     = (sgn && b[WIDTH-1]) ? -b : b;
  assign last   = cnt == CW'(WIDTH - 1);
  assign busy   = state != S_IDLE;
  assign stall  = rd_hilo & busy;
  assign prod   = neg_q ? -acc : acc;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .opnd   (opnd),
    .div    (div_r),
    .acc_nxt(acc_nxt)
  );
`ifdef MULDIV_DIV_EN
  logic neg_r, dz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (state == S_IDLE && start) begin
      neg_r <= sgn & a[WIDTH-1];
      dz    <= is_div && b == '0;
    end
  end
  // A zero divisor leaves |a| in the remainder half, so the normal
  // dividend-sign correction already yields hi = a; only lo needs forcing.
  assign fix_hi    = div_r ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
  assign fix_lo    = div_r ? (dz ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign fix_dz    = dz;
  assign div_entry = S_CALC;
`else
  assign fix_hi    = div_r ? hi : prod[2*WIDTH-1:WIDTH];
  assign fix_lo    = div_r ? lo : prod[WIDTH-1:0];
  assign fix_dz    = 1'b0;
  assign div_entry = S_FIX;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == S_IDLE ? (start ? (is_div ? div_entry : S_CALC) : S_IDLE) :
                state == S_CALC ? (last ? S_FIX : S_CALC) : S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      div_r    <= 1'b0;
      neg_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= state == S_FIX;
      div_zero <= state == S_FIX && fix_dz;
      if (state == S_IDLE && start) begin
        cnt   <= '0;
        div_r <= is_div;
        neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc   <= {{WIDTH{1'b0}}, is_div ? am : bm};
        opnd  <= is_div ? bm : am;
      end
      if (state == S_CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state == S_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end
endmodule
